// File: rtl/alu_seq_pkg.sv
// Shared op codes, FSM state type and iterative-op decode for alu_seq.
// ALU_SEQ_DIV_EN adds div/divu/rem/remu to the iterative op set.
package alu_seq_pkg;

   localparam int unsigned OP_ADD   = 0;
   localparam int unsigned OP_SUB   = 1;
   localparam int unsigned OP_AND   = 2;
   localparam int unsigned OP_OR    = 3;
   localparam int unsigned OP_XOR   = 4;
   localparam int unsigned OP_SLT   = 5;
   localparam int unsigned OP_SLTU  = 6;
   localparam int unsigned OP_SRA   = 7;
   localparam int unsigned OP_SRL   = 8;
   localparam int unsigned OP_SLL   = 9;
   localparam int unsigned OP_MUL   = 10;
   localparam int unsigned OP_ADDI  = 11;
   localparam int unsigned OP_SUBI  = 12;
   localparam int unsigned OP_ANDI  = 13;
   localparam int unsigned OP_ORI   = 14;
   localparam int unsigned OP_XORI  = 15;
   localparam int unsigned OP_SLTI  = 16;
   localparam int unsigned OP_SLTIU = 17;
   localparam int unsigned OP_SRAI  = 18;
   localparam int unsigned OP_SRLI  = 19;
   localparam int unsigned OP_SLLI  = 20;
   localparam int unsigned OP_LUI   = 21;
   localparam int unsigned OP_AUIPC = 22;
   localparam int unsigned OP_LW    = 23;
   localparam int unsigned OP_SW    = 24;
   localparam int unsigned OP_JR    = 25;
   localparam int unsigned OP_JALR  = 26;
   localparam int unsigned OP_JAL   = 27;
   localparam int unsigned OP_BEQ   = 28;
   localparam int unsigned OP_BNE   = 29;
   localparam int unsigned OP_BLT   = 30;
   localparam int unsigned OP_BGE   = 31;
   localparam int unsigned OP_BLTU  = 32;
   localparam int unsigned OP_BGEU  = 33;
   localparam int unsigned OP_DIV   = 34;
   localparam int unsigned OP_DIVU  = 35;
   localparam int unsigned OP_REM   = 36;
   localparam int unsigned OP_REMU  = 37;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ITER = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   // Ops that run on the multi-cycle unit rather than the single-cycle datapath.
   function automatic logic is_iterative(input int unsigned op);
`ifdef ALU_SEQ_DIV_EN
      return (op == OP_MUL) || ((op >= OP_DIV) && (op <= OP_REMU));
`else
      return op == OP_MUL;
`endif
   endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative unit: shift-add multiplier, plus a restoring divider when
// ALU_SEQ_DIV_EN is defined. One bit per cycle, WIDTH steps per operation.
module alu_seq_muldiv
   import alu_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SEL_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             start,
   input  logic [SEL_W-1:0] op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

   logic             start_ok_c;
   logic             last_c;
   logic             busy_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] acc_q, x_q, y_q;
   logic [WIDTH-1:0] acc_src_c, x_src_c, y_src_c;
   logic [WIDTH-1:0] mul_acc_c, mul_x_c, mul_y_c;
   logic [WIDTH-1:0] acc_nxt_c, x_nxt_c, y_nxt_c;
   logic [WIDTH-1:0] final_c;

   assign start_ok_c = start & is_iterative(32'(op));
   assign last_c     = busy_q & (cnt_q == CNT_W'(WIDTH - 1));

   // Multiplier step: acc += x when y[0]; x walks left, y walks right.
   assign mul_acc_c = y_src_c[0] ? (acc_src_c + x_src_c) : acc_src_c;
   assign mul_x_c   = x_src_c << 1;
   assign mul_y_c   = y_src_c >> 1;

`ifdef ALU_SEQ_DIV_EN
   logic             div_q, want_rem_q, neg_q_q, neg_r_q;
   logic             div_in_c, sgn_in_c, neg_a_c, neg_b_c, div_mode_c;
   logic [WIDTH:0]   sh_c;
   logic [WIDTH-1:0] div_acc_c, div_x_c;

   assign div_in_c   = (32'(op) >= OP_DIV) && (32'(op) <= OP_REMU);
   assign sgn_in_c   = (32'(op) == OP_DIV) || (32'(op) == OP_REM);
   assign neg_a_c    = sgn_in_c & a[WIDTH-1];
   assign neg_b_c    = sgn_in_c & b[WIDTH-1];
   assign div_mode_c = start_ok_c ? div_in_c : div_q;

   // The first step runs on the accept edge straight from the operands.
   always_comb begin
      acc_src_c = acc_q;
      x_src_c   = x_q;
      y_src_c   = y_q;
      if (start_ok_c) begin
         acc_src_c = '0;
         x_src_c   = neg_a_c ? (~a + WIDTH'(1)) : a;
         y_src_c   = neg_b_c ? (~b + WIDTH'(1)) : b;
      end
   end

   // Restoring step: shift next dividend bit into the remainder, trial-subtract.
   always_comb begin
      sh_c      = {acc_src_c, x_src_c[WIDTH-1]};
      div_acc_c = sh_c[WIDTH-1:0];
      div_x_c   = {x_src_c[WIDTH-2:0], 1'b0};
      if (sh_c >= {1'b0, y_src_c}) begin
         div_acc_c = WIDTH'(sh_c - {1'b0, y_src_c});
         div_x_c   = {x_src_c[WIDTH-2:0], 1'b1};
      end
   end

   always_comb begin
      acc_nxt_c = mul_acc_c;
      x_nxt_c   = mul_x_c;
      y_nxt_c   = mul_y_c;
      if (div_mode_c) begin
         acc_nxt_c = div_acc_c;
         x_nxt_c   = div_x_c;
         y_nxt_c   = y_src_c;
      end
   end

   // Sign fix on magnitudes; a zero divisor keeps the all-ones quotient unsigned.
   always_comb begin
      final_c = acc_nxt_c;
      if (div_q) begin
         if (want_rem_q) final_c = neg_r_q ? (~acc_nxt_c + WIDTH'(1)) : acc_nxt_c;
         else            final_c = neg_q_q ? (~x_nxt_c + WIDTH'(1)) : x_nxt_c;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q      <= 1'b0;
         want_rem_q <= 1'b0;
         neg_q_q    <= 1'b0;
         neg_r_q    <= 1'b0;
      end else if (start_ok_c && !flush) begin
         div_q      <= div_in_c;
         want_rem_q <= (32'(op) == OP_REM) || (32'(op) == OP_REMU);
         neg_q_q    <= (neg_a_c ^ neg_b_c) & (b != '0);
         neg_r_q    <= neg_a_c;
      end
   end
`else
   always_comb begin
      acc_src_c = acc_q;
      x_src_c   = x_q;
      y_src_c   = y_q;
      if (start_ok_c) begin
         acc_src_c = '0;
         x_src_c   = a;
         y_src_c   = b;
      end
   end

   assign acc_nxt_c = mul_acc_c;
   assign x_nxt_c   = mul_x_c;
   assign y_nxt_c   = mul_y_c;
   assign final_c   = mul_acc_c;
`endif

   // Step counter and datapath registers; done pulses for one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         done   <= 1'b0;
         result <= '0;
         acc_q  <= '0;
         x_q    <= '0;
         y_q    <= '0;
      end else if (flush) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start_ok_c || busy_q) begin
            acc_q <= acc_nxt_c;
            x_q   <= x_nxt_c;
            y_q   <= y_nxt_c;
         end
         if (start_ok_c) begin
            busy_q <= 1'b1;
            cnt_q  <= CNT_W'(1);
         end else if (busy_q) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_c) begin
               busy_q <= 1'b0;
               done   <= 1'b1;
               result <= final_c;
            end
         end
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU between the execute operand muxes and the z4 writeback register.
// Define ALU_SEQ_DIV_EN to add the iterative div/divu/rem/remu ops (codes 34-37).
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SEL_W   = 6,
   parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] operand1,
   input  logic [WIDTH-1:0] operand2,
   input  logic [SEL_W-1:0] alu_select,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] z4_input,
   output logic             flag_zero,
   output logic             flag_lt,
   output logic             flag_ltu
);

   state_t             state, state_nxt;
   logic               alive_q;
   int unsigned        op_c;
   logic               iter_c, accept_c, start_c, lt_c, ltu_c;
   logic [SHAMT_W-1:0] shamt_c;
   logic [WIDTH-1:0]   alu_res_c;
   logic               md_done;
   logic [WIDTH-1:0]   md_result;
   logic               pend_lt_q, pend_ltu_q;

   assign op_c     = 32'(alu_select);
   assign iter_c   = is_iterative(op_c);
   assign in_ready = alive_q & ((state == ST_IDLE) | ((state == ST_HOLD) & out_ready));
   assign accept_c = in_valid & in_ready;
   assign start_c  = accept_c & iter_c & ~flush;
   assign lt_c     = $signed(operand1) < $signed(operand2);
   assign ltu_c    = operand1 < operand2;
   assign shamt_c  = operand2[SHAMT_W-1:0];

   // Holds in_ready low until the first clock after reset release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) alive_q <= 1'b0;
      else     alive_q <= 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (accept_c) state_nxt = iter_c ? ST_ITER : ST_HOLD;
            ST_ITER: if (md_done)  state_nxt = ST_HOLD;
            ST_HOLD: begin
               if (accept_c)       state_nxt = iter_c ? ST_ITER : ST_HOLD;
               else if (out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // Single-cycle datapath; every unlisted code behaves as add.
   always_comb begin
      alu_res_c = operand1 + operand2;
      case (op_c)
         OP_SUB, OP_SUBI, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU:
            alu_res_c = operand1 - operand2;
         OP_AND, OP_ANDI:   alu_res_c = operand1 & operand2;
         OP_OR, OP_ORI:     alu_res_c = operand1 | operand2;
         OP_XOR, OP_XORI:   alu_res_c = operand1 ^ operand2;
         OP_SLT, OP_SLTI:   alu_res_c = WIDTH'(lt_c);
         OP_SLTU, OP_SLTIU: alu_res_c = WIDTH'(ltu_c);
         OP_SRA, OP_SRAI:   alu_res_c = WIDTH'($signed(operand1) >>> shamt_c);
         OP_SRL, OP_SRLI:   alu_res_c = operand1 >> shamt_c;
         OP_SLL, OP_SLLI:   alu_res_c = operand1 << shamt_c;
         OP_LUI:            alu_res_c = operand2;
         OP_ADD, OP_ADDI, OP_MUL, OP_AUIPC, OP_LW, OP_SW, OP_JR, OP_JALR, OP_JAL,
         OP_DIV, OP_DIVU, OP_REM, OP_REMU:
            alu_res_c = operand1 + operand2;
         default:           alu_res_c = operand1 + operand2;
      endcase
   end

   alu_seq_muldiv #(
      .WIDTH (WIDTH),
      .SEL_W (SEL_W)
   ) u_muldiv (
      .clk    (clk),
      .rst    (rst),
      .flush  (flush),
      .start  (start_c),
      .op     (alu_select),
      .a      (operand1),
      .b      (operand2),
      .done   (md_done),
      .result (md_result)
   );

   // Result and flags land together; iterative ops keep their accept-time compare flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid  <= 1'b0;
         z4_input   <= '0;
         flag_zero  <= 1'b0;
         flag_lt    <= 1'b0;
         flag_ltu   <= 1'b0;
         pend_lt_q  <= 1'b0;
         pend_ltu_q <= 1'b0;
      end else begin
         out_valid <= (state_nxt == ST_HOLD);
         if (start_c) begin
            pend_lt_q  <= lt_c;
            pend_ltu_q <= ltu_c;
         end
         if (!flush) begin
            if (accept_c && !iter_c) begin
               z4_input  <= alu_res_c;
               flag_zero <= (alu_res_c == '0);
               flag_lt   <= lt_c;
               flag_ltu  <= ltu_c;
            end else if ((state == ST_ITER) && md_done) begin
               z4_input  <= md_result;
               flag_zero <= (md_result == '0);
               flag_lt   <= pend_lt_q;
               flag_ltu  <= pend_ltu_q;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Randomised self-checking bench for alu_seq against a plain-arithmetic model.
// Compile with ALU_SEQ_DIV_EN to include the divider cases.
`timescale 1ns/1ps
module tb_alu_seq;

   localparam int unsigned W = 32;
   localparam int unsigned ITER_LAT = W + 1;

   logic         clk = 1'b0;
   logic         rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0] operand1, operand2, z4_input;
   logic [5:0]   alu_select;
   logic         flag_zero, flag_lt, flag_ltu;

   int n_checks = 0;
   int n_errors = 0;
   int hs_count = 0;

   int unsigned  q_op[$];
   logic [W-1:0] q_a[$], q_b[$];

   alu_seq dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .operand1   (operand1),
      .operand2   (operand2),
      .alu_select (alu_select),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .z4_input   (z4_input),
      .flag_zero  (flag_zero),
      .flag_lt    (flag_lt),
      .flag_ltu   (flag_ltu)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (out_valid && out_ready) hs_count <= hs_count + 1;

   function automatic logic ref_is_iter(input int unsigned op);
`ifdef ALU_SEQ_DIV_EN
      return (op == 10) || (op >= 34 && op <= 37);
`else
      return op == 10;
`endif
   endfunction

   function automatic logic [W-1:0] ref_result(input int unsigned op, input logic [W-1:0] a, input logic [W-1:0] b);
      longint          sa, sb;
      longint unsigned ua, ub, p2;
      int              sh;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = 64'(a);
      ub = 64'(b);
      sh = int'(b[4:0]);
      p2 = 64'd1 << sh;
      case (op)
         1, 12, 28, 29, 30, 31, 32, 33: return a - b;
         2, 13: return a & b;
         3, 14: return a | b;
         4, 15: return a ^ b;
         5, 16: return {31'b0, sa < sb};
         6, 17: return {31'b0, ua < ub};
         7, 18: return 32'(sa >>> sh);
         8, 19: return 32'(ua / p2);
         9, 20: return 32'(ua * p2);
         10:    return 32'(ua * ub);
         21:    return b;
`ifdef ALU_SEQ_DIV_EN
         34:    return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
         35:    return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
         36:    return (b == 0) ? a : 32'(sa % sb);
         37:    return (b == 0) ? a : 32'(ua % ub);
`endif
         default: return a + b;
      endcase
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_out(input string tag, input int unsigned op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] exp;
      exp = ref_result(op, a, b);
      check({tag, "_res"}, 64'(z4_input), 64'(exp));
      check({tag, "_zero"}, 64'(flag_zero), 64'(exp == 0));
      check({tag, "_lt"}, 64'(flag_lt), 64'($signed(a) < $signed(b)));
      check({tag, "_ltu"}, 64'(flag_ltu), 64'(a < b));
   endtask

   // Issue one op from a negedge and follow it to out_valid.
   task automatic run_op(input string tag, input int unsigned op, input logic [W-1:0] a, input logic [W-1:0] b);
      int   n, lat;
      logic rdy_bad;
      n = 0;
      while (!in_ready && n < 100) begin @(negedge clk); n++; end
      check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      alu_select = 6'(op); operand1 = a; operand2 = b; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      rdy_bad = 1'b0;
      while (!out_valid && lat < 100) begin
         if (in_ready) rdy_bad = 1'b1;
         in_valid = 1'b1; operand1 = ~a; operand2 = a; alu_select = 6'd1;
         @(negedge clk);
         lat++;
      end
      in_valid = 1'b0;
      check({tag, "_lat"}, 64'(lat), ref_is_iter(op) ? 64'(ITER_LAT) : 64'd1);
      if (ref_is_iter(op)) check({tag, "_iter_ready"}, 64'(rdy_bad), 64'd0);
      check_out(tag, op, a, b);
   endtask

   // Stream the queued single-cycle ops one per cycle with out_ready high.
   task automatic run_b2b(input string tag);
      int n;
      n = q_op.size();
      for (int i = 0; i <= n; i++) begin
         if (i > 0) begin
            check({tag, "_valid"}, 64'(out_valid), 64'd1);
            check_out(tag, q_op[i-1], q_a[i-1], q_b[i-1]);
         end
         if (i < n) begin
            check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
            alu_select = 6'(q_op[i]); operand1 = q_a[i]; operand2 = q_b[i]; in_valid = 1'b1;
            @(negedge clk);
         end else begin
            in_valid = 1'b0;
         end
      end
      q_op.delete(); q_a.delete(); q_b.delete();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned  op;
      logic [W-1:0] a, b, hold_v;
      int           h0;
      logic         bad;

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      operand1 = '0; operand2 = '0; alu_select = '0;
      repeat (2) @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_z4", 64'(z4_input), 64'd0);
      check("rst_flags", 64'({flag_zero, flag_lt, flag_ltu}), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      rst = 1'b0;
      #1 check("post_rst_in_ready_lo", 64'(in_ready), 64'd0);
      @(negedge clk);
      check("post_rst_in_ready_hi", 64'(in_ready), 64'd1);

      // Directed back-to-back stream.
      q_op = '{0, 1, 6, 7, 8, 21, 29};
      q_a  = '{32'd5, 32'd3, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h7};
      q_b  = '{32'd7, 32'd5, 32'd1, 32'h21, 32'h21, 32'hABCD_0000, 32'h7};
      run_b2b("b2b_dir");
      @(negedge clk);
      check("idle_out_valid", 64'(out_valid), 64'd0);

      // Random back-to-back single-cycle ops.
      for (int i = 0; i < 40; i++) begin
         op = $urandom_range(0, 63);
         while (ref_is_iter(op)) op = $urandom_range(0, 63);
         q_op.push_back(op);
         q_a.push_back(($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom);
         q_b.push_back(($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom);
      end
      run_b2b("b2b_rnd");
      @(negedge clk);

      run_op("mul_dir", 10, 32'hFFFF_FFFF, 32'd3);
      run_op("add_after_mul", 0, 32'd100, 32'hFFFF_FF9C);
`ifdef ALU_SEQ_DIV_EN
      run_op("div_ovf", 34, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("remu_zero", 37, 32'd7, 32'd0);
      run_op("divu_dir", 35, 32'd100, 32'd7);
      run_op("div_zero", 34, 32'hFFFF_FFF9, 32'd0);
      run_op("rem_neg", 36, 32'hFFFF_FFF9, 32'd2);
`endif
      for (int i = 0; i < 6; i++) begin
         op = 10;
`ifdef ALU_SEQ_DIV_EN
         if (i % 2 == 1) op = $urandom_range(34, 37);
`endif
         a = $urandom;
         b = ($urandom_range(0, 4) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom);
         run_op("iter_rnd", op, a, b);
      end

      // Backpressure: result and flags must stay put and in_ready low.
      @(negedge clk);
      out_ready = 1'b0;
      run_op("bp_add", 1, 32'd2, 32'd9);
      hold_v = ref_result(1, 32'd2, 32'd9);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; alu_select = 6'd0; operand1 = 32'd1; operand2 = 32'd1;
         @(negedge clk);
         check("bp_z4", 64'(z4_input), 64'(hold_v));
         check("bp_flags", 64'({flag_zero, flag_lt, flag_ltu}), 64'b011);
         check("bp_in_ready", 64'(in_ready), 64'd0);
         check("bp_out_valid", 64'(out_valid), 64'd1);
      end
      in_valid = 1'b0;
      h0 = hs_count;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("bp_handshakes", 64'(hs_count - h0), 64'd1);
      check("bp_release_valid", 64'(out_valid), 64'd0);
      check("bp_idle_z4_hold", 64'(z4_input), 64'(hold_v));

      // Flush at ITER cycle 10 discards the multiply.
      alu_select = 6'd10; operand1 = 32'd1234; operand2 = 32'd5678; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) bad = 1'b1;
         @(negedge clk);
      end
      check("flush_no_valid", 64'(bad), 64'd0);
      check("flush_in_ready", 64'(in_ready), 64'd1);
      run_op("flush_next_add", 0, 32'd40, 32'd2);

      // Flush in the accept cycle drops that op.
      @(negedge clk);
      alu_select = 6'd0; operand1 = 32'd9; operand2 = 32'd9; in_valid = 1'b1; flush = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b0;
      check("flush_accept_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
      check("flush_accept_valid2", 64'(out_valid), 64'd0);

      // Asynchronous reset in the middle of a multiply.
      run_op("pre_rst_add", 0, 32'h1111, 32'h2222);
      alu_select = 6'd10; operand1 = 32'd77; operand2 = 32'd3; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_z4", 64'(z4_input), 64'd0);
      check("arst_out_valid", 64'(out_valid), 64'd0);
      check("arst_flags", 64'({flag_zero, flag_lt, flag_ltu}), 64'd0);
      check("arst_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_op("post_arst_add", 0, 32'hFFFF_FFFF, 32'd1);
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the processor's combinational ALU.
- Accepts one operation per transaction over a valid/ready input and produces a registered result plus branch flags over a valid/ready output.
- Single-cycle ops complete in 1 cycle.
- MUL, and DIV/REM when enabled, run on an iterative unit for WIDTH cycles.
- Sits between the execute-stage operand muxes and the z4 writeback register.

Parameters:
- WIDTH, 32, datapath width in bits; power of two, minimum 8.
- SEL_W, 6, width of alu_select.
- SHAMT_W, $clog2(WIDTH), number of shift-amount bits taken from operand2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  synchronous abort of the in-flight operation
- in_valid  in  1  operands and select are valid
- in_ready  out  1  block can accept an operation
- operand1  in  WIDTH  first operand
- operand2  in  WIDTH  second operand or immediate
- alu_select  in  SEL_W  operation code
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- z4_input  out  WIDTH  result
- flag_zero  out  1  result == 0
- flag_lt  out  1  signed operand1 < operand2
- flag_ltu  out  1  unsigned operand1 < operand2

Behaviour:
- Reset: all outputs 0, state IDLE; in_ready becomes 1 on the first clock after reset deasserts.
- States:
  - IDLE (no result held)
  - ITER (iterative op running)
  - HOLD (result held, out_valid=1)
- in_ready = (state==IDLE) | (state==HOLD & out_ready). This gives back-to-back single-cycle throughput of 1/cycle.
- Accept occurs when in_valid & in_ready.
- Single-cycle op accepted: result, flags and out_valid are registered next edge → HOLD.
- Iterative op accepted → ITER. The operation runs WIDTH cycles, then the result is registered → HOLD. Latency is WIDTH+1 cycles from accept to out_valid.
- HOLD with out_ready=1 and no new accept → IDLE. z4_input holds its value; out_valid=0.
- HOLD with out_valid=1 and out_ready=0: outputs stable, in_ready=0.
- Op codes:
  - 0/11 add; 1/12 sub; 2/13 and; 3/14 or; 4/15 xor.
  - 5 slt signed; 16 slti signed; 6/17 sltu.
  - 7/18 sra arithmetic; 8/19 srl; 9/20 sll. All shifts use operand2[SHAMT_W-1:0] only.
  - 10 mul: low WIDTH bits, iterative.
  - 21 lui: passes operand2.
  - 22–27 add (auipc, lw, sw, jr, jalr, jal).
  - 28–33 sub (branches).
  - 34 div, 35 divu, 36 rem, 37 remu (see Optional Feature).
  - Any other code: add.
- Arithmetic: all modulo 2^WIDTH; carry is discarded.
- slt/sltu results are zero-extended 1 or 0.
- Flags are registered with the result for every op and are computed from the accepted operands.
- flush: ITER or HOLD → IDLE next edge; out_valid=0; partial result discarded. flush during an accept cycle discards that operation.
- rst asserted mid-ITER: immediate abort to reset values.
- ITER ignores in_valid; in_ready=0 throughout.

Optional Feature:
- Macro: ALU_SEQ_DIV_EN.
- With the macro defined: codes 34–37 use a restoring iterative divider, WIDTH cycles, same latency as mul. Signed ops work on magnitudes and fix the sign afterwards.
  - Divide by zero: quotient = all ones, remainder = dividend.
  - Signed overflow (MIN / -1): quotient = MIN, remainder = 0.
- Without the macro: codes 34–37 fall to default add as single-cycle ops, and no divider logic is synthesised.

Decomposition:
- Package alu_seq_pkg holds:
  - op-code localparams (OP_ADD … OP_REMU)
  - the state enum
  - the is_iterative(op) function
- One sub-module, alu_seq_muldiv: shift-add multiplier plus the optional divider.
  - Interface: start, op, a, b → done, result.
  - WIDTH-cycle counter; cleared by flush/rst.

Test Plan:
- Back-to-back ops with out_ready=1 → out_valid every cycle.
  - add 5+7 → 12.
  - sub 3-5 → 0xFFFFFFFE with flag_lt=1, flag_ltu=1.
  - sltu 0xFFFFFFFF,1 → 0.
- sra 0x80000000 by operand2=0x21 → 0xC0000000 (shift 1); srl of the same → 0x40000000.
- mul 0xFFFFFFFF*3 → 0xFFFFFFFD after exactly 33 cycles; in_ready=0 throughout ITER.
- ALU_SEQ_DIV_EN cases:
  - div 0x80000000/0xFFFFFFFF → 0x80000000.
  - remu 7/0 → 7.
  - divu 100/7 → 14.
- Backpressure: out_ready=0 for 5 cycles → z4_input and flags stable, in_ready=0; release → one handshake only.
- Aborts:
  - flush at ITER cycle 10 → IDLE, no out_valid; next add returns correctly.
  - rst mid-mul → all outputs 0 asynchronously.
